matvec_stream_ctrl: RTL

//  Parametrised AXIS front-end/back-end for the matrix-vector compute pipe (SRT -> CORDIC -> cubic).

---
 rtl/matvec_pkg.sv | 24 ++
 rtl/matvec_stream_ctrl_if.sv | 12 +
 rtl/matvec_stream_ctrl_fifo.sv | 49 ++++
 rtl/matvec_stream_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
// Shared types and elaboration helpers for the matrix-vector stream controller.
package matvec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned p = 1; p < v; p = p << 1) r++;
      return r;
   endfunction

   function automatic int unsigned load_beats(input int unsigned rows,
                                              input int unsigned cols,
                                              input int unsigned lanes);
      return (rows * cols) / lanes;
   endfunction

endpackage

// File: rtl/matvec_stream_ctrl_if.sv
// AXI-Stream bundle (data/valid/ready/last) with master and slave views.
interface matvec_stream_ctrl_if #(
   parameter int unsigned W = 64
);
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;
   logic         tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/matvec_stream_ctrl_fifo.sv
// Synchronous FIFO for result words; combinational read of the head entry.
module axis_sync_fifo
   import matvec_pkg::*;
#(
   parameter  int unsigned WIDTH = 33,
   parameter  int unsigned DEPTH = 64,
   localparam int unsigned AW    = clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic [AW:0]      count_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   always_comb begin
      count_d = count_q + CW'(push_i) - CW'(pop_i);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   assign pop_data_o = mem_q[rd_ptr_q];
   assign count_o    = count_q;
   assign full_o     = (count_q == CW'(DEPTH));
   assign empty_o    = (count_q == '0);
endmodule

// File: rtl/matvec_stream_ctrl.sv
// AXIS front/back end for the matrix-vector pipe: matrix load, vector issue,
// tag line matching the datapath latency, and credit-limited result FIFO.
module matvec_stream_ctrl
   import matvec_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned OUT_WIDTH  = 32,
   parameter int unsigned LANES      = 4,
   parameter int unsigned ROWS       = 3,
   parameter int unsigned COLS       = 4,
   parameter int unsigned PIPE_LAT   = 45,
   parameter int unsigned FIFO_DEPTH = 64
) (
   input  logic                             aclk,
   input  logic                             aresetn,
   input  logic                             cfg_keep_mat,
   matvec_stream_ctrl_if.slave              s_axis,
   matvec_stream_ctrl_if.master             m_axis,
   output logic [ROWS*COLS*DATA_WIDTH-1:0]  coef,
   output logic                             mat_valid,
   output logic [LANES*DATA_WIDTH-1:0]      dp_vec,
   output logic                             dp_in_valid,
   input  logic [OUT_WIDTH-1:0]             dp_result,
   output logic                             err_short
);
   localparam int unsigned VW         = LANES * DATA_WIDTH;
   localparam int unsigned LOAD_BEATS = load_beats(ROWS, COLS, LANES);
   localparam int unsigned BW         = (LOAD_BEATS > 1) ? clog2(LOAD_BEATS) : 1;
   localparam int unsigned CW         = clog2(FIFO_DEPTH) + 1;

   state_t                          state_q, state_d;
   logic [BW-1:0]                   beat_q, beat_d;
   logic [ROWS*COLS*DATA_WIDTH-1:0] coef_q, coef_d;
   logic                            mat_valid_q, mat_valid_d;
   logic [PIPE_LAT-1:0]             tag_v_q, tag_l_q;
   logic [CW-1:0]                   inflight_q, inflight_d;
   logic [CW-1:0]                   fifo_count, credit;
   logic [OUT_WIDTH:0]              fifo_rd;
   logic fifo_full, fifo_empty, m_hs, keep_hit, last_load;
   logic rdy, hs, load_beat, issue;

   assign keep_hit  = cfg_keep_mat && mat_valid_q;
   assign last_load = (beat_q == BW'(LOAD_BEATS - 1));
   assign credit    = CW'(FIFO_DEPTH) - fifo_count - inflight_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // beat_q stays 0 outside LOAD, so the IDLE load beat is always beat 0
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      coef_d      = coef_q;
      mat_valid_d = mat_valid_q;
      if (load_beat) begin
         coef_d[int'(beat_q)*VW +: VW] = s_axis.tdata;
         if (s_axis.tlast) begin
            mat_valid_d = 1'b0;
            beat_d      = '0;
            state_d     = ST_IDLE;
         end else if (last_load) begin
            mat_valid_d = 1'b1;
            beat_d      = '0;
            state_d     = ST_STREAM;
         end else begin
            mat_valid_d = 1'b0;
            beat_d      = beat_q + BW'(1);
            state_d     = ST_LOAD;
         end
      end else if (issue) begin
         state_d = s_axis.tlast ? ST_DRAIN : ST_STREAM;
      end else if (state_q == ST_DRAIN && m_hs && m_axis.tlast) begin
         state_d = ST_IDLE;
      end
   end

   always_comb begin
      rdy = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_LOAD: rdy = 1'b1;
         ST_STREAM:        rdy = !fifo_full && (credit != '0);
         default:          rdy = 1'b0;
      endcase
      s_axis.tready = aresetn && rdy;
      hs            = s_axis.tvalid && aresetn && rdy;
      load_beat     = hs && (state_q == ST_LOAD || (state_q == ST_IDLE && !keep_hit));
      issue         = hs && (state_q == ST_STREAM || (state_q == ST_IDLE && keep_hit));
      err_short     = load_beat && s_axis.tlast;
      dp_in_valid   = issue;
      dp_vec        = issue ? s_axis.tdata : '0;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         beat_q      <= '0;
         coef_q      <= '0;
         mat_valid_q <= 1'b0;
      end else begin
         beat_q      <= beat_d;
         coef_q      <= coef_d;
         mat_valid_q <= mat_valid_d;
      end
   end

   // Tag line mirrors the datapath latency so results exit with their last flag
   always_comb begin
      inflight_d = inflight_q + CW'(issue) - CW'(tag_v_q[PIPE_LAT-1]);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         tag_v_q    <= '0;
         tag_l_q    <= '0;
         inflight_q <= '0;
      end else begin
         tag_v_q    <= {tag_v_q[PIPE_LAT-2:0], issue};
         tag_l_q    <= {tag_l_q[PIPE_LAT-2:0], issue && s_axis.tlast};
         inflight_q <= inflight_d;
      end
   end

   axis_sync_fifo #(
      .WIDTH (OUT_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (aclk),
      .rst_ni      (aresetn),
      .push_i      (tag_v_q[PIPE_LAT-1]),
      .push_data_i ({tag_l_q[PIPE_LAT-1], dp_result}),
      .pop_i       (m_hs),
      .pop_data_o  (fifo_rd),
      .count_o     (fifo_count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign m_axis.tvalid = !fifo_empty;
   assign m_axis.tdata  = fifo_empty ? '0 : fifo_rd[OUT_WIDTH-1:0];
   assign m_axis.tlast  = !fifo_empty && fifo_rd[OUT_WIDTH];
   assign m_hs          = m_axis.tvalid && m_axis.tready;

   assign coef      = coef_q;
   assign mat_valid = mat_valid_q;
endmodule
